ps2_scan_rx: RTL and testbench
==============================

Name: ps2_scan_rx

Overview:
- PS/2 keyboard receiver that sits directly upstream of the scancode-to-letter decoder.
- Deserialises the keyboard's ps2_clk/ps2_data frames into scancode bytes and tracks the F0 (break) and E0 (extended) prefixes.
- Presents each completed key byte as two nibbles, dig2 (high) and dig1 (low), with a one-cycle valid strobe that downstream consumes.

Parameters:
- TIMEOUT_CYC, 200000, clk cycles allowed between ps2_clk falling edges mid-frame before abort (2 ms at 100 MHz).
- FILTER_LEN, 8, number of agreeing samples needed by the optional ps2_clk glitch filter (range 2..16).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ps2_clk  input  1  raw keyboard clock, asynchronous to clk.
- ps2_data  input  1  raw keyboard data, asynchronous to clk.
- dig1  output  4  scancode bits [3:0], held until next key_valid.
- dig2  output  4  scancode bits [7:4], held until next key_valid.
- key_valid  output  1  one-cycle strobe, new key byte on dig2/dig1.
- key_break  output  1  qualifies key_valid: byte was preceded by F0 (key release).
- key_ext  output  1  qualifies key_valid: byte was preceded by E0.
- frame_err  output  1  one-cycle strobe on parity, stop or timeout error.

Behaviour:
- Reset (async, rst_n=0):
  - dig1=0, dig2=0, key_valid=0, key_break=0, key_ext=0, frame_err=0.
  - Synchronisers reset to 1; FSM returns to IDLE; bit counter, shift register, pending flags and timeout counter clear.
- Input synchronisation: 2-FF synchroniser on each of ps2_clk and ps2_data. A falling edge is detected when the synced clk was 1 last cycle and is 0 now. Data is sampled from the synced ps2_data in the same cycle.
- FSM, advancing only on a detected falling edge:
  - IDLE: if data=0 (start bit), go to DATA with bitcnt=0. If data=1, stay in IDLE and ignore the edge.
  - DATA: shift the bit in, LSB first. After the 8th bit (bitcnt=7), go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: check stop bit = 1 and odd parity (8 data bits plus parity bit contain an odd number of ones). Always return to IDLE.
- Byte handling, on a good frame:
  - 0xF0: set brk_pend; no strobe.
  - 0xE0: set ext_pend; no strobe.
  - Any other byte:
    - key_valid=1 for exactly one cycle; dig2=byte[7:4], dig1=byte[3:0].
    - key_break=brk_pend and key_ext=ext_pend, held with the dig outputs.
    - Clear both pending flags.
  - Sequence E0 F0 xx gives a single strobe with key_break=1 and key_ext=1.
- Bad parity or stop bit:
  - frame_err=1 for one cycle; no key_valid; dig outputs unchanged.
  - Both pending flags are cleared.
- Timeout:
  - The counter clears on every falling edge and counts while the FSM is not IDLE.
  - At TIMEOUT_CYC-1 the FSM goes to IDLE and frame_err pulses once. The partial byte is discarded and the pending flags are cleared.
  - The counter is held at 0 in IDLE.
- Latency: key_valid is high in the 3rd clk cycle after the stop-bit falling edge appears on the ps2_clk pin (2 sync stages plus 1 output register). The optional filter adds FILTER_LEN cycles.
- key_valid and frame_err never assert in the same cycle. No backpressure: the downstream must accept a strobe whenever it occurs.
- Reset mid-frame: the next frame decodes normally from its start bit.

Optional Feature:
- Macro PS2_GLITCH_FILTER_EN.
- When defined: the synced ps2_clk passes through a FILTER_LEN-deep sample shift register. The filtered level changes only when all FILTER_LEN samples agree, and edge detection uses the filtered level. The data sample is taken from the synced ps2_data at filtered-edge time. The filter register resets to all ones.
- When undefined: edge detection uses the 2-FF synced clock directly, and FILTER_LEN is unused.

Test Plan:
- Send frame 0x1C (good parity) -> one key_valid pulse, dig2=1, dig1=C, key_break=0, key_ext=0, frame_err never asserted.
- Send F0 then 1C -> no strobe after F0; exactly one key_valid after 1C with dig2=1, dig1=C, key_break=1, key_ext=0.
- Send E0, F0, 5A -> single key_valid, dig2=5, dig1=A, key_break=1, key_ext=1. A following 0x24 -> dig2=2, dig1=4, both flags 0.
- Send 0x2D with parity bit inverted -> frame_err pulse, no key_valid, dig outputs keep previous value. Next good 0x15 -> dig2=1, dig1=5.
- Clock 5 bits of a frame, then hold ps2_clk high for TIMEOUT_CYC cycles -> exactly one frame_err pulse, FSM in IDLE. Next good 0x1B -> dig2=1, dig1=B.
- Assert rst_n=0 after 4 data bits, release, then send 0x5A -> all outputs 0 during reset, then a single key_valid with dig2=5, dig1=A. Repeat with PS2_GLITCH_FILTER_EN defined, injecting 2-cycle ps2_clk low glitches -> no extra bits shifted, same result.

Source files
------------

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 keyboard frame receiver with F0/E0 prefix tracking; PS2_GLITCH_FILTER_EN adds a ps2_clk filter.
// Latency 3 clk from stop-bit edge on the pin (+FILTER_LEN when filtered); no backpressure, all strobes are one-shot.
module ps2_scan_rx #(
    parameter int TIMEOUT_CYC = 200000,
    parameter int FILTER_LEN  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic       key_valid,
    output logic       key_break,
    output logic       key_ext,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_PAR  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [1:0]    clk_s_q;
    logic [1:0]    dat_s_q;
    logic          fall;
    logic          din;

    logic [1:0]    state_q,  state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q,  shift_d;
    logic          par_q,    par_d;
    logic [TW-1:0] tmo_q,    tmo_d;
    logic          brk_pend_q, brk_pend_d;
    logic          ext_pend_q, ext_pend_d;
    logic [7:0]    dig_q,    dig_d;
    logic          kbrk_q,   kbrk_d;
    logic          kext_q,   kext_d;
    logic          kv_q,     kv_d;
    logic          fe_q,     fe_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s_q <= 2'b11;
            dat_s_q <= 2'b11;
        end else begin
            clk_s_q <= {clk_s_q[0], ps2_clk};
            dat_s_q <= {dat_s_q[0], ps2_data};
        end
    end

    assign din = dat_s_q[1];

`ifdef PS2_GLITCH_FILTER_EN
    // Filtered level only moves once FILTER_LEN consecutive samples agree.
    logic [FILTER_LEN-1:0] filt_q;
    logic                  lvl_q, lvl_d;
    logic                  all0, all1;

    assign all0 = (filt_q == '0);
    assign all1 = &filt_q;
    assign lvl_d = all0 ? 1'b0 : (all1 ? 1'b1 : lvl_q);
    assign fall  = lvl_q & all0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '1;
            lvl_q  <= 1'b1;
        end else begin
            filt_q <= {filt_q[FILTER_LEN-2:0], clk_s_q[1]};
            lvl_q  <= lvl_d;
        end
    end
`else
    logic clk_prev_q;
    logic unused_filter_cfg;

    assign unused_filter_cfg = (FILTER_LEN != 0);
    assign fall = clk_prev_q & ~clk_s_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clk_prev_q <= 1'b1;
        else        clk_prev_q <= clk_s_q[1];
    end
`endif

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        brk_pend_d = brk_pend_q;
        ext_pend_d = ext_pend_q;
        dig_d      = dig_q;
        kbrk_d     = kbrk_q;
        kext_d     = kext_q;
        kv_d       = 1'b0;
        fe_d       = 1'b0;
        if (fall) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!din) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d  = {din, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_PAR;
                end
                S_PAR: begin
                    par_d   = din;
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    // Odd parity: data plus parity bit must hold an odd count of ones.
                    if (din && (^{shift_q, par_q})) begin
                        if (shift_q == 8'hF0) begin
                            brk_pend_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_pend_d = 1'b1;
                        end else begin
                            kv_d       = 1'b1;
                            dig_d      = shift_q;
                            kbrk_d     = brk_pend_q;
                            kext_d     = ext_pend_q;
                            brk_pend_d = 1'b0;
                            ext_pend_d = 1'b0;
                        end
                    end else begin
                        fe_d       = 1'b1;
                        brk_pend_d = 1'b0;
                        ext_pend_d = 1'b0;
                    end
                end
            endcase
        end else if (state_q == S_IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d    = S_IDLE;
            tmo_d      = '0;
            shift_d    = '0;
            fe_d       = 1'b1;
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            brk_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            dig_q      <= '0;
            kbrk_q     <= 1'b0;
            kext_q     <= 1'b0;
            kv_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            brk_pend_q <= brk_pend_d;
            ext_pend_q <= ext_pend_d;
            dig_q      <= dig_d;
            kbrk_q     <= kbrk_d;
            kext_q     <= kext_d;
            kv_q       <= kv_d;
            fe_q       <= fe_d;
        end
    end

    assign dig2      = dig_q[7:4];
    assign dig1      = dig_q[3:0];
    assign key_valid = kv_q;
    assign key_break = kbrk_q;
    assign key_ext   = kext_q;
    assign frame_err = fe_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Bench for ps2_scan_rx: directed scenarios plus random frames scored against a prefix-tracking model.
module tb_ps2_scan_rx;
    localparam int TO   = 1000;
    localparam int HALF = 15;
`ifdef PS2_GLITCH_FILTER_EN
    localparam int LAT = 3 + 8;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] dig1, dig2;
    logic       key_valid, key_break, key_ext, frame_err;

    ps2_scan_rx #(.TIMEOUT_CYC(TO), .FILTER_LEN(8)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .dig1(dig1), .dig2(dig2), .key_valid(key_valid), .key_break(key_break),
        .key_ext(key_ext), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int kv_cnt = 0, fe_cnt = 0, both_cnt = 0, kv_cyc = 0, stop_cyc = 0;
    int vectors = 0, miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid) begin
                kv_cnt = kv_cnt + 1;
                kv_cyc = cyc;
            end
            if (frame_err) fe_cnt = fe_cnt + 1;
            if (key_valid && frame_err) both_cnt = both_cnt + 1;
        end
    end

    // Reference model: pending prefix flags and expected event counts.
    logic       m_brk = 1'b0, m_ext = 1'b0, m_kbrk = 1'b0, m_kext = 1'b0;
    logic [7:0] m_dig = 8'h00;
    int         m_kv = 0, m_fe = 0;

    task automatic model_frame(input logic [7:0] b, input bit bad);
        if (bad) begin
            m_fe++; m_brk = 1'b0; m_ext = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            m_kv++; m_dig = b; m_kbrk = m_brk; m_kext = m_ext;
            m_brk = 1'b0; m_ext = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            if (glitch) begin
                wait_cyc(HALF / 2);
                ps2_clk = 1'b0;
                wait_cyc(2);
                ps2_clk = 1'b1;
                wait_cyc(HALF - HALF / 2 - 2);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit bad, input bit glitch);
        send_bits(b, bad, 11, glitch);
        model_frame(b, bad);
        wait_cyc(LAT + 5);
    endtask

    task automatic test_reset;
        wait_cyc(4);
        @(negedge clk);
        vectors++;
        if ({dig2, dig1, key_valid, key_break, key_ext, frame_err} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs got %h expected 000", {dig2, dig1, key_valid, key_break, key_ext, frame_err});
        end
        rst_n = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_make;
        int kv0, fe0;
        kv0 = kv_cnt; fe0 = fe_cnt;
        frame(8'h1C, 1'b0, 1'b0);
        vectors++;
        if (kv_cnt - kv0 !== 1) begin miscompares++; $display("FAIL make_kv_pulses got %0d expected 1", kv_cnt - kv0); end
        vectors++;
        if ({dig2, dig1, key_break, key_ext} !== 10'h070) begin
            miscompares++; $display("FAIL make_value got %h/%b%b expected 1c/00", {dig2, dig1}, key_break, key_ext);
        end
        vectors++;
        if (fe_cnt !== fe0) begin miscompares++; $display("FAIL make_no_err got %0d errors expected 0", fe_cnt - fe0); end
        vectors++;
        if (kv_cyc - stop_cyc !== LAT) begin miscompares++; $display("FAIL make_latency got %0d expected %0d", kv_cyc - stop_cyc, LAT); end
    endtask

    task automatic test_break;
        int kv0;
        kv0 = kv_cnt;
        frame(8'hF0, 1'b0, 1'b0);
        vectors++;
        if (kv_cnt !== kv0) begin miscompares++; $display("FAIL break_prefix_strobe got %0d expected 0", kv_cnt - kv0); end
        frame(8'h1C, 1'b0, 1'b0);
        vectors++;
        if (kv_cnt - kv0 !== 1) begin miscompares++; $display("FAIL break_kv_pulses got %0d expected 1", kv_cnt - kv0); end
        vectors++;
        if ({dig2, dig1, key_break, key_ext} !== {8'h1C, 2'b10}) begin
            miscompares++; $display("FAIL break_value got %h/%b%b expected 1c/10", {dig2, dig1}, key_break, key_ext);
        end
    endtask

    task automatic test_ext_break;
        int kv0;
        kv0 = kv_cnt;
        frame(8'hE0, 1'b0, 1'b0);
        frame(8'hF0, 1'b0, 1'b0);
        frame(8'h5A, 1'b0, 1'b0);
        vectors++;
        if (kv_cnt - kv0 !== 1) begin miscompares++; $display("FAIL extbrk_kv_pulses got %0d expected 1", kv_cnt - kv0); end
        vectors++;
        if ({dig2, dig1, key_break, key_ext} !== {8'h5A, 2'b11}) begin
            miscompares++; $display("FAIL extbrk_value got %h/%b%b expected 5a/11", {dig2, dig1}, key_break, key_ext);
        end
        frame(8'h24, 1'b0, 1'b0);
        vectors++;
        if ({dig2, dig1, key_break, key_ext} !== {8'h24, 2'b00}) begin
            miscompares++; $display("FAIL extbrk_next got %h/%b%b expected 24/00", {dig2, dig1}, key_break, key_ext);
        end
    endtask

    task automatic test_parity_err;
        int kv0, fe0;
        frame(8'hE0, 1'b0, 1'b0);
        kv0 = kv_cnt; fe0 = fe_cnt;
        frame(8'h2D, 1'b1, 1'b0);
        vectors++;
        if (fe_cnt - fe0 !== 1 || kv_cnt !== kv0) begin
            miscompares++; $display("FAIL parity_events got err=%0d kv=%0d expected err=1 kv=0", fe_cnt - fe0, kv_cnt - kv0);
        end
        vectors++;
        if ({dig2, dig1} !== 8'h24) begin miscompares++; $display("FAIL parity_hold got %h expected 24", {dig2, dig1}); end
        frame(8'h15, 1'b0, 1'b0);
        vectors++;
        if ({dig2, dig1, key_break, key_ext} !== {8'h15, 2'b00}) begin
            miscompares++; $display("FAIL parity_recover got %h/%b%b expected 15/00", {dig2, dig1}, key_break, key_ext);
        end
    endtask

    task automatic test_timeout;
        int kv0, fe0;
        frame(8'hF0, 1'b0, 1'b0);
        kv0 = kv_cnt; fe0 = fe_cnt;
        send_bits(8'h33, 1'b0, 5, 1'b0);
        wait_cyc(TO + 50);
        model_frame(8'h00, 1'b1);
        vectors++;
        if (fe_cnt - fe0 !== 1 || kv_cnt !== kv0) begin
            miscompares++; $display("FAIL timeout_events got err=%0d kv=%0d expected err=1 kv=0", fe_cnt - fe0, kv_cnt - kv0);
        end
        frame(8'h1B, 1'b0, 1'b0);
        vectors++;
        if ({dig2, dig1, key_break, key_ext} !== {8'h1B, 2'b00} || fe_cnt - fe0 !== 1) begin
            miscompares++; $display("FAIL timeout_recover got %h/%b%b err=%0d expected 1b/00 err=1", {dig2, dig1}, key_break, key_ext, fe_cnt - fe0);
        end
    endtask

    task automatic reset_mid_frame(input string tag);
        send_bits(8'hA5, 1'b0, 5, 1'b0);
        rst_n = 1'b0;
        wait_cyc(3);
        @(negedge clk);
        vectors++;
        if ({dig2, dig1, key_valid, key_break, key_ext, frame_err} !== 12'h000) begin
            miscompares++; $display("FAIL %s_in_reset got %h expected 000", tag, {dig2, dig1, key_valid, key_break, key_ext, frame_err});
        end
        rst_n = 1'b1;
        m_brk = 1'b0; m_ext = 1'b0;
        wait_cyc(5);
    endtask

    task automatic test_reset_midframe;
        int kv0, fe0;
        reset_mid_frame("midrst");
        kv0 = kv_cnt; fe0 = fe_cnt;
        frame(8'h5A, 1'b0, 1'b0);
        vectors++;
        if (kv_cnt - kv0 !== 1 || fe_cnt !== fe0 || {dig2, dig1, key_break, key_ext} !== {8'h5A, 2'b00}) begin
            miscompares++; $display("FAIL midrst_decode got %h/%b%b kv=%0d err=%0d expected 5a/00 kv=1 err=0",
                                    {dig2, dig1}, key_break, key_ext, kv_cnt - kv0, fe_cnt - fe0);
        end
    endtask

    task automatic test_glitch;
`ifdef PS2_GLITCH_FILTER_EN
        int kv0, fe0;
        reset_mid_frame("glitch");
        kv0 = kv_cnt; fe0 = fe_cnt;
        frame(8'h5A, 1'b0, 1'b1);
        vectors++;
        if (kv_cnt - kv0 !== 1 || fe_cnt !== fe0 || {dig2, dig1} !== 8'h5A) begin
            miscompares++; $display("FAIL glitch_decode got %h kv=%0d err=%0d expected 5a kv=1 err=0",
                                    {dig2, dig1}, kv_cnt - kv0, fe_cnt - fe0);
        end
`endif
    endtask

    task automatic test_random;
        logic [7:0] b;
        int         sel, kv0, fe0;
        kv0 = kv_cnt; fe0 = fe_cnt;
        m_kv = 0; m_fe = 0;
        for (int i = 0; i < 40; i++) begin
            b   = 8'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 8'hF0;
            if (sel == 1) b = 8'hE0;
            frame(b, sel == 2, 1'b0);
            vectors++;
            if (kv_cnt - kv0 !== m_kv || fe_cnt - fe0 !== m_fe) begin
                miscompares++; $display("FAIL rand_events[%0d] got kv=%0d err=%0d expected kv=%0d err=%0d",
                                        i, kv_cnt - kv0, fe_cnt - fe0, m_kv, m_fe);
            end
            if (m_kv > 0) begin
                vectors++;
                if ({dig2, dig1, key_break, key_ext} !== {m_dig, m_kbrk, m_kext}) begin
                    miscompares++; $display("FAIL rand_value[%0d] got %h/%b%b expected %h/%b%b",
                                            i, {dig2, dig1}, key_break, key_ext, m_dig, m_kbrk, m_kext);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_make;
        test_break;
        test_ext_break;
        test_parity_err;
        test_timeout;
        test_reset_midframe;
        test_glitch;
        test_random;
        vectors++;
        if (both_cnt !== 0) begin miscompares++; $display("FAIL kv_err_overlap got %0d expected 0", both_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
